memory_controller: RTL and testbench

//  Owns the single byte-wide RAM/IO port. Arbitrates between instruction fetch (icache, 4-byte

---
 rtl/memory_controller_pkg.sv | 46 ++++
 rtl/memory_controller.sv | 176 +++++++++++++++++
 tb/tb_memory_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_controller_pkg.sv
// Shared types and defaults for the byte-wide memory controller.
// Op/len encodings match what the LSB and icache drive onto the request ports.
package memory_controller_pkg;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_READ  = 2'd1,
        MC_WRITE = 2'd2
    } mc_state_t;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_LSB    = 1'b1
    } mc_owner_t;

    typedef enum logic {
        OPTYPE_LD = 1'b0,
        OPTYPE_ST = 1'b1
    } op_type_t;

    typedef logic [1:0] len_t;

    localparam len_t LEN_B = 2'b01;
    localparam len_t LEN_H = 2'b10;
    localparam len_t LEN_W = 2'b11;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
    localparam logic [31:0] IO_MASK_DEFAULT = 32'h0003_0000;

    // The illegal length 00 is treated as a single byte.
    function automatic logic [2:0] len_to_bytes(input len_t len);
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            LEN_W:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [31:0] shifted;
        shifted = word >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/memory_controller.sv
// Owns the byte-wide RAM/IO port: arbitrates LSB over icache, splits requests
// into byte accesses and reassembles little-endian read data.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT,
    parameter logic [31:0] IO_MASK = IO_MASK_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clr_in,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        icache_to_mc_ready,
    input  logic [31:0] icache_to_mc_addr,
    output logic        mc_to_icache_done,
    output logic [31:0] mc_to_icache_data,
    input  logic        lsb_to_mc_ready,
    input  logic [1:0]  lsb_to_mc_len,
    input  op_type_t    lsb_to_mc_opType,
    input  logic [31:0] lsb_to_mc_addr,
    input  logic [31:0] lsb_to_mc_data,
    output logic        mc_valid,
    output logic        mc_to_lsb_ld_done,
    output logic        mc_to_lsb_st_done,
    output logic [31:0] mc_to_lsb_result
);

    // state    | meaning
    // MC_IDLE  | no access in flight; grants LSB before icache
    // MC_READ  | issuing byte addresses, collecting mem_din one cycle behind
    // MC_WRITE | driving one store byte per cycle, holds while IO buffer is full

    mc_state_t   state;
    mc_owner_t   owner;
    logic [2:0]  cnt;
    logic [2:0]  n_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [7:0]  din_hold;
    logic        hold_vld;
    logic        rdy_q;

    logic [2:0]  cnt_nxt;
    logic [7:0]  din_eff;
    logic [31:0] rd_merged;
    logic        wr_stall;
    logic        any_done;

    assign cnt_nxt  = cnt + 3'd1;
    assign din_eff  = hold_vld ? din_hold : mem_din;
    assign wr_stall = ((mem_a & IO_MASK) == IO_BASE) && io_buffer_full;
    assign any_done = mc_to_icache_done | mc_to_lsb_ld_done | mc_to_lsb_st_done;
    assign mem_wr   = (state == MC_WRITE) && rdy_in && !wr_stall;

    // Read data trails the address by one cycle, so cnt=k captures byte k-1.
    always_comb begin
        rd_merged = rdata_q;
        case (cnt)
            3'd1:    rd_merged[7:0]   = din_eff;
            3'd2:    rd_merged[15:8]  = din_eff;
            3'd3:    rd_merged[23:16] = din_eff;
            3'd4:    rd_merged[31:24] = din_eff;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state             <= MC_IDLE;
            owner             <= OWN_ICACHE;
            cnt               <= 3'd0;
            n_q               <= 3'd0;
            addr_q            <= 32'd0;
            wdata_q           <= 32'd0;
            rdata_q           <= 32'd0;
            din_hold          <= 8'd0;
            hold_vld          <= 1'b0;
            rdy_q             <= 1'b0;
            mem_a             <= 32'd0;
            mem_dout          <= 8'd0;
            mc_valid          <= 1'b0;
            mc_to_icache_done <= 1'b0;
            mc_to_icache_data <= 32'd0;
            mc_to_lsb_ld_done <= 1'b0;
            mc_to_lsb_st_done <= 1'b0;
            mc_to_lsb_result  <= 32'd0;
        end else if (!rdy_in) begin
            // RAM keeps answering while frozen; keep the byte that was in flight.
            rdy_q <= 1'b0;
            if (rdy_q && state == MC_READ && cnt != 3'd0) begin
                din_hold <= mem_din;
                hold_vld <= 1'b1;
            end
        end else begin
            rdy_q             <= 1'b1;
            hold_vld          <= 1'b0;
            mc_valid          <= 1'b0;
            mc_to_icache_done <= 1'b0;
            mc_to_lsb_ld_done <= 1'b0;
            mc_to_lsb_st_done <= 1'b0;
            case (state)
                MC_IDLE: begin
                    if (!clr_in && !any_done) begin
                        cnt     <= 3'd0;
                        rdata_q <= 32'd0;
                        if (lsb_to_mc_ready) begin
                            owner    <= OWN_LSB;
                            mc_valid <= 1'b1;
                            addr_q   <= lsb_to_mc_addr;
                            wdata_q  <= lsb_to_mc_data;
                            n_q      <= len_to_bytes(lsb_to_mc_len);
                            mem_a    <= lsb_to_mc_addr;
                            if (lsb_to_mc_opType == OPTYPE_ST) begin
                                mem_dout <= lsb_to_mc_data[7:0];
                                state    <= MC_WRITE;
                            end else begin
                                state    <= MC_READ;
                            end
                        end else if (icache_to_mc_ready) begin
                            owner  <= OWN_ICACHE;
                            addr_q <= icache_to_mc_addr;
                            n_q    <= 3'd4;
                            mem_a  <= icache_to_mc_addr;
                            state  <= MC_READ;
                        end
                    end
                end
                MC_READ: begin
                    if (clr_in) begin
                        state <= MC_IDLE;
                        cnt   <= 3'd0;
                    end else begin
                        rdata_q <= rd_merged;
                        if (cnt == n_q) begin
                            state <= MC_IDLE;
                            cnt   <= 3'd0;
                            if (owner == OWN_LSB) begin
                                mc_to_lsb_ld_done <= 1'b1;
                                mc_to_lsb_result  <= rd_merged;
                            end else begin
                                mc_to_icache_done <= 1'b1;
                                mc_to_icache_data <= rd_merged;
                            end
                        end else begin
                            cnt <= cnt_nxt;
                            if (cnt_nxt < n_q)
                                mem_a <= addr_q + {29'd0, cnt_nxt};
                        end
                    end
                end
                MC_WRITE: begin
                    // Stores are committed, so a flush does not cut them short.
                    if (!wr_stall) begin
                        if (cnt_nxt == n_q) begin
                            state             <= MC_IDLE;
                            cnt               <= 3'd0;
                            mc_to_lsb_st_done <= 1'b1;
                        end else begin
                            cnt      <= cnt_nxt;
                            mem_a    <= addr_q + {29'd0, cnt_nxt};
                            mem_dout <= byte_sel(wdata_q, cnt_nxt[1:0]);
                        end
                    end
                end
                default: state <= MC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: vector table of LSB accesses plus hand sequences
// for arbitration, IO stall, flush, freeze and reset; scoreboard queues on done pulses.
module tb_memory_controller;
    import memory_controller_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clr_in, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        icache_to_mc_ready;
    logic [31:0] icache_to_mc_addr;
    logic        mc_to_icache_done;
    logic [31:0] mc_to_icache_data;
    logic        lsb_to_mc_ready;
    logic [1:0]  lsb_to_mc_len;
    op_type_t    lsb_to_mc_opType;
    logic [31:0] lsb_to_mc_addr, lsb_to_mc_data;
    logic        mc_valid, mc_to_lsb_ld_done, mc_to_lsb_st_done;
    logic [31:0] mc_to_lsb_result;

    memory_controller dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr),
        .icache_to_mc_ready(icache_to_mc_ready), .icache_to_mc_addr(icache_to_mc_addr),
        .mc_to_icache_done(mc_to_icache_done), .mc_to_icache_data(mc_to_icache_data),
        .lsb_to_mc_ready(lsb_to_mc_ready), .lsb_to_mc_len(lsb_to_mc_len),
        .lsb_to_mc_opType(lsb_to_mc_opType), .lsb_to_mc_addr(lsb_to_mc_addr),
        .lsb_to_mc_data(lsb_to_mc_data), .mc_valid(mc_valid),
        .mc_to_lsb_ld_done(mc_to_lsb_ld_done), .mc_to_lsb_st_done(mc_to_lsb_st_done),
        .mc_to_lsb_result(mc_to_lsb_result)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    typedef struct {
        op_type_t    op;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] data;
        logic        io_full;
        logic [31:0] expv;
        int          lat;
    } vec_t;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          ld_cnt = 0, st_cnt = 0, ic_cnt = 0;
    logic [7:0]  pre  [logic [31:0]];
    logic [7:0]  wram [logic [31:0]];
    wr_t         wlog [$];
    logic [31:0] exp_ld_q [$];
    logic [31:0] exp_ic_q [$];
    logic [31:0] exp_st_q [$];
    vec_t        vecs [9];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (wram.exists(a)) return wram[a];
        if (pre.exists(a))  return pre[a];
        return 8'h00;
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return {ram_rd(a + 32'd3), ram_rd(a + 32'd2), ram_rd(a + 32'd1), ram_rd(a)};
    endfunction

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b11) ? 4 : int'(len);
    endfunction

    // RAM answers one cycle after the address; writes land on the clock edge.
    always @(posedge clk_in) begin
        mem_din <= ram_rd(mem_a);
        if (mem_wr) begin
            wram[mem_a] = mem_dout;
            wlog.push_back('{mem_a, mem_dout, cyc});
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event, want one (cycle %0d)", name, cyc);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) pre[a + i] = w[8*i +: 8];
    endtask

    // Advance to just after the falling edge and retire any done pulses.
    task automatic step();
        @(negedge clk_in);
        #1;
        if (mc_to_lsb_ld_done) begin
            ld_cnt++;
            if (exp_ld_q.size() == 0) fail_msg("ld_expected");
            else check("ld_result", mc_to_lsb_result, exp_ld_q.pop_front());
        end
        if (mc_to_icache_done) begin
            ic_cnt++;
            if (exp_ic_q.size() == 0) fail_msg("ic_expected");
            else check("ic_data", mc_to_icache_data, exp_ic_q.pop_front());
        end
        if (mc_to_lsb_st_done) begin
            st_cnt++;
            if (exp_st_q.size() == 0) fail_msg("st_expected");
            else check("st_last_addr", mem_a, exp_st_q.pop_front());
        end
    endtask

    function automatic int cnt_of(input int which);
        return (which == 0) ? ld_cnt : (which == 1) ? st_cnt : ic_cnt;
    endfunction

    task automatic wait_done(input string name, input int which, output int dcyc);
        int base;
        base = cnt_of(which);
        dcyc = -1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (cnt_of(which) != base) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) fail_msg(name);
    endtask

    task automatic drive_lsb(input op_type_t op, input logic [1:0] len,
                             input logic [31:0] a, input logic [31:0] d);
        lsb_to_mc_ready  = 1'b1;
        lsb_to_mc_opType = op;
        lsb_to_mc_len    = len;
        lsb_to_mc_addr   = a;
        lsb_to_mc_data   = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, d, w0;
        vec_t v;

        rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
        icache_to_mc_ready = 1'b0; icache_to_mc_addr = 32'd0;
        lsb_to_mc_ready = 1'b0; lsb_to_mc_len = 2'b01; lsb_to_mc_opType = OPTYPE_LD;
        lsb_to_mc_addr = 32'd0; lsb_to_mc_data = 32'd0;

        vecs[0] = '{OPTYPE_LD, 2'b11, 32'h0000_1000, 32'h4433_2211, 1'b0, 32'h4433_2211, 6};
        vecs[1] = '{OPTYPE_LD, 2'b01, 32'h0000_2003, 32'hFFEE_DD80, 1'b0, 32'h0000_0080, 3};
        vecs[2] = '{OPTYPE_LD, 2'b10, 32'h0000_2100, 32'hA5A5_BEEF, 1'b0, 32'h0000_BEEF, 4};
        vecs[3] = '{OPTYPE_ST, 2'b10, 32'h0000_2000, 32'h1234_BEEF, 1'b0, 32'hCCCC_BEEF, 3};
        vecs[4] = '{OPTYPE_ST, 2'b11, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 5};
        vecs[5] = '{OPTYPE_ST, 2'b01, 32'h0000_4001, 32'hAABB_CC77, 1'b0, 32'hCCCC_CC77, 2};
        vecs[6] = '{OPTYPE_LD, 2'b11, 32'hFFFF_FFFE, 32'h0403_0201, 1'b0, 32'h0403_0201, 6};
        vecs[7] = '{OPTYPE_LD, 2'b10, 32'h0003_0010, 32'h7766_9988, 1'b1, 32'h0000_9988, 4};
        vecs[8] = '{OPTYPE_ST, 2'b11, 32'h0003_0020, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 5};

        repeat (3) step();
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_pulses", {28'd0, mc_valid, mc_to_lsb_ld_done, mc_to_lsb_st_done, mc_to_icache_done}, 32'd0);
        check("rst_ld_result", mc_to_lsb_result, 32'd0);
        check("rst_ic_data", mc_to_icache_data, 32'd0);
        rst_in = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            preload(v.addr, (v.op == OPTYPE_LD) ? v.data : 32'hCCCC_CCCC);
            io_buffer_full = v.io_full;
            w0 = wlog.size();
            if (v.op == OPTYPE_LD) exp_ld_q.push_back(v.expv);
            else exp_st_q.push_back(v.addr + 32'(nbytes(v.len) - 1));
            t = cyc;
            drive_lsb(v.op, v.len, v.addr, v.data);
            step();
            check($sformatf("v%0d_mc_valid", i), {31'd0, mc_valid}, 32'd1);
            lsb_to_mc_ready = 1'b0;
            wait_done($sformatf("v%0d_done", i), (v.op == OPTYPE_LD) ? 0 : 1, d);
            check($sformatf("v%0d_latency", i), d - t, v.lat);
            if (v.op == OPTYPE_ST) begin
                check($sformatf("v%0d_ram", i), ram_word(v.addr), v.expv);
                check($sformatf("v%0d_nwrites", i), wlog.size() - w0, nbytes(v.len));
                if (wlog.size() > w0) check($sformatf("v%0d_first_wr", i), wlog[w0].c, t + 1);
            end
            io_buffer_full = 1'b0;
            step();
        end

        // icache and LSB request together: LSB first, fetch after the load's done.
        exp_ld_q.push_back(32'h0000_0044);
        exp_ic_q.push_back(32'h4433_2211);
        t = cyc;
        drive_lsb(OPTYPE_LD, 2'b01, 32'h0000_1003, 32'd0);
        icache_to_mc_ready = 1'b1;
        icache_to_mc_addr  = 32'h0000_1000;
        step();
        check("arb_mc_valid", {31'd0, mc_valid}, 32'd1);
        check("arb_lsb_addr", mem_a, 32'h0000_1003);
        lsb_to_mc_ready = 1'b0;
        wait_done("arb_ld_done", 0, d);
        check("arb_ld_latency", d - t, 3);
        wait_done("arb_ic_done", 2, d);
        icache_to_mc_ready = 1'b0;
        check("arb_ic_latency", d - t, 10);
        step();

        // IO byte store held off by a full buffer.
        preload(32'h0003_0000, 32'hCCCC_CCCC);
        exp_st_q.push_back(32'h0003_0000);
        w0 = wlog.size();
        t = cyc;
        io_buffer_full = 1'b1;
        drive_lsb(OPTYPE_ST, 2'b01, 32'h0003_0000, 32'h0000_0041);
        step();
        lsb_to_mc_ready = 1'b0;
        step();
        check("io_stall_mem_wr", {31'd0, mem_wr}, 32'd0);
        step();
        step();
        io_buffer_full = 1'b0;
        wait_done("io_st_done", 1, d);
        check("io_st_latency", d - t, 5);
        check("io_nwrites", wlog.size() - w0, 1);
        if (wlog.size() > w0) begin
            check("io_write_cycle", wlog[w0].c, t + 4);
            check("io_write_data", {24'd0, wlog[w0].d}, 32'h41);
        end
        step();

        // Flush mid-fetch: no done, controller back in IDLE.
        t = cyc;
        icache_to_mc_ready = 1'b1;
        icache_to_mc_addr  = 32'h0000_1000;
        step();
        step();
        clr_in = 1'b1;
        icache_to_mc_ready = 1'b0;
        d = ic_cnt;
        step();
        clr_in = 1'b0;
        repeat (10) step();
        check("clr_fetch_no_done", ic_cnt, d);

        // Flush in IDLE blocks the grant that cycle.
        exp_ld_q.push_back(32'h0000_BEEF);
        t = cyc;
        clr_in = 1'b1;
        drive_lsb(OPTYPE_LD, 2'b10, 32'h0000_2100, 32'd0);
        step();
        check("clr_blocks_grant", {31'd0, mc_valid}, 32'd0);
        clr_in = 1'b0;
        step();
        check("clr_late_grant", {31'd0, mc_valid}, 32'd1);
        lsb_to_mc_ready = 1'b0;
        wait_done("clr_ld_done", 0, d);
        check("clr_ld_latency", d - t, 5);
        step();

        // Flush during a word store: all four bytes still written.
        preload(32'h0000_5000, 32'hCCCC_CCCC);
        exp_st_q.push_back(32'h0000_5003);
        w0 = wlog.size();
        t = cyc;
        drive_lsb(OPTYPE_ST, 2'b11, 32'h0000_5000, 32'h1122_3344);
        step();
        lsb_to_mc_ready = 1'b0;
        step();
        clr_in = 1'b1;
        step();
        clr_in = 1'b0;
        wait_done("clr_sw_done", 1, d);
        check("clr_sw_latency", d - t, 5);
        check("clr_sw_nwrites", wlog.size() - w0, 4);
        check("clr_sw_ram", ram_word(32'h0000_5000), 32'h1122_3344);
        step();

        // Freeze three cycles in the middle of a word load.
        exp_ld_q.push_back(32'h4433_2211);
        t = cyc;
        drive_lsb(OPTYPE_LD, 2'b11, 32'h0000_1000, 32'd0);
        step();
        lsb_to_mc_ready = 1'b0;
        step();
        rdy_in = 1'b0;
        step();
        check("frz_mem_a_1", mem_a, 32'h0000_1001);
        check("frz_mem_wr", {31'd0, mem_wr}, 32'd0);
        step();
        check("frz_mem_a_2", mem_a, 32'h0000_1001);
        step();
        rdy_in = 1'b1;
        wait_done("frz_ld_done", 0, d);
        check("frz_ld_latency", d - t, 9);
        step();

        // Reset together with flush in the middle of a store abandons the rest.
        w0 = wlog.size();
        d = st_cnt;
        drive_lsb(OPTYPE_ST, 2'b11, 32'h0000_6000, 32'h5566_7788);
        step();
        lsb_to_mc_ready = 1'b0;
        step();
        rst_in = 1'b1;
        clr_in = 1'b1;
        step();
        rst_in = 1'b0;
        clr_in = 1'b0;
        check("rst_mid_mem_a", mem_a, 32'd0);
        check("rst_mid_mem_wr", {31'd0, mem_wr}, 32'd0);
        repeat (6) step();
        check("rst_mid_nwrites", wlog.size() - w0, 2);
        check("rst_mid_no_done", st_cnt, d);

        check("sb_ld_drained", exp_ld_q.size(), 0);
        check("sb_ic_drained", exp_ic_q.size(), 0);
        check("sb_st_drained", exp_st_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
